// File: rtl/spart_pkg.sv
// spart_pkg: definitions shared by the mini SPART transmit, receive and
// baud-generator blocks.
//   spart_state_e  - serial frame FSM state encoding
//   OVERSAMPLE_DEF - default number of enable pulses per bit period
//   DATA_BITS_DEF  - default payload width
//   START_BIT / STOP_BIT - 8N1 framing line levels
package spart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } spart_state_e;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS_DEF  = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/spart_sync_edge.sv
// spart_sync_edge: two-flop synchroniser for an asynchronous serial line, plus
// one flop holding the previous synchronised value for falling-edge detection.
// All flops reset high so an idle line produces no edge out of reset.
//   clk_i  - system clock
//   rst_i  - asynchronous active-high reset
//   d_i    - asynchronous serial input
//   d_s_o  - synchronised line level
//   fall_o - synchronised line went high-to-low this cycle
module spart_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic d_s_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign d_s_o  = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/spart_rx.sv
// spart_rx: UART receive stage of the mini SPART. Deserialises 8N1 frames,
// LSB first, using a 16x oversampling enable shared with the transmitter.
//   clk     - system clock
//   rst     - asynchronous active-high reset
//   en      - one-clk pulse at OVERSAMPLE x baud
//   RxD     - serial line, asynchronous, idle high
//   clr_rda - one-clk pulse from bus interface when data is read
//   data    - last correctly framed byte
//   rda     - receive data available
//   ferr    - last frame had its stop bit sampled low
//   oerr    - a byte completed while rda was still set
module spart_rx
  import spart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 RxD,
  input  logic                 clr_rda,
  output logic [DATA_BITS-1:0] data,
  output logic                 rda,
  output logic                 ferr,
  output logic                 oerr
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic rxd_s;
  logic fall;

  spart_sync_edge u_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .d_i    (RxD),
    .d_s_o  (rxd_s),
    .fall_o (fall)
  );

  spart_state_e         state_q;
  logic [TW-1:0]        tick_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 rda_q;
  logic                 ferr_q;
  logic                 oerr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rda_q   <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      // Bus read clears status; a byte completing in the same cycle
      // overrides rda below, so the completion wins.
      if (clr_rda) begin
        rda_q  <= 1'b0;
        oerr_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          // Edge detection runs every clk; only a fresh high-to-low
          // transition starts a frame, so a held-low line cannot retrigger.
          if (fall) begin
            tick_q  <= TICK_HALF;
            state_q <= START;
          end
        end

        START: begin
          if (en) begin
            if (tick_q != '0) begin
              tick_q <= tick_q - TICK_ONE;
            end else if (rxd_s == START_BIT) begin
              tick_q  <= TICK_FULL;
              bit_q   <= '0;
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
            end
          end
        end

        DATA: begin
          if (en) begin
            if (tick_q != '0) begin
              tick_q <= tick_q - TICK_ONE;
            end else begin
              shift_q <= {rxd_s, shift_q[DATA_BITS-1:1]};
              tick_q  <= TICK_FULL;
              bit_q   <= bit_q + BIT_ONE;
              if (bit_q == BIT_LAST) begin
                state_q <= STOP;
              end
            end
          end
        end

        STOP: begin
          if (en) begin
            if (tick_q != '0) begin
              tick_q <= tick_q - TICK_ONE;
            end else begin
              state_q <= IDLE;
              if (rxd_s == STOP_BIT) begin
                data_q <= shift_q;
                rda_q  <= 1'b1;
                ferr_q <= 1'b0;
                if (rda_q && !clr_rda) begin
                  oerr_q <= 1'b1;
                end
              end else begin
                ferr_q <= 1'b1;
              end
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign data = data_q;
  assign rda  = rda_q;
  assign ferr = ferr_q;
  assign oerr = oerr_q;

endmodule

// File: tb/tb_spart_rx.sv
module tb_spart_rx;

  localparam int unsigned BIT_CLK  = 64;   // 16 en pulses, one every 4 clk
  localparam int unsigned FRAME_EN = 152;  // en pulses from edge detect to stop sample

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       RxD = 1'b1;
  logic       clr_rda = 1'b0;
  logic [7:0] data;
  logic       rda;
  logic       ferr;
  logic       oerr;

  spart_rx #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .RxD     (RxD),
    .clr_rda (clr_rda),
    .data    (data),
    .rda     (rda),
    .ferr    (ferr),
    .oerr    (oerr)
  );

  always #5 clk = ~clk;

  // Requests from the stimulus process (owned by it).
  int unsigned req_seq = 0;
  logic [7:0]  req_byte = 8'h00;
  logic        req_stop = 1'b1;
  int unsigned clr_seq = 0;
  logic        coinc_req = 1'b0;
  int unsigned lit_seq = 0;
  string       lit_tag = "";
  logic [7:0]  lit_data = 8'h00;
  logic        lit_rda = 1'b0;
  logic        lit_ferr = 1'b0;
  logic        lit_oerr = 1'b0;

  // Frame-level behavioural model: a frame started on the line completes
  // FRAME_EN en pulses after its edge has passed the synchroniser.
  logic [7:0]  m_data = 8'h00;
  logic        m_rda = 1'b0;
  logic        m_ferr = 1'b0;
  logic        m_oerr = 1'b0;
  logic        pend_valid = 1'b0;
  logic [7:0]  pend_byte = 8'h00;
  logic        pend_stop = 1'b1;
  int unsigned pend_dly = 0;
  int unsigned pend_ens = 0;
  int unsigned seen_seq = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data     = 8'h00;
      m_rda      = 1'b0;
      m_ferr     = 1'b0;
      m_oerr     = 1'b0;
      pend_valid = 1'b0;
    end else begin
      if (clr_rda) begin
        m_rda  = 1'b0;
        m_oerr = 1'b0;
      end
      if (req_seq != seen_seq) begin
        seen_seq   = req_seq;
        pend_valid = 1'b1;
        pend_byte  = req_byte;
        pend_stop  = req_stop;
        pend_dly   = 2;   // two more clk until the edge is seen and the frame starts
        pend_ens   = 0;
      end else if (pend_valid) begin
        if (pend_dly != 0) begin
          pend_dly--;
        end else if (en) begin
          pend_ens++;
          if (pend_ens == FRAME_EN) begin
            pend_valid = 1'b0;
            if (pend_stop) begin
              if (m_rda) m_oerr = 1'b1;
              m_data = pend_byte;
              m_rda  = 1'b1;
              m_ferr = 1'b0;
            end else begin
              m_ferr = 1'b1;
            end
          end
        end
      end
    end
  end

  // en every 4 clk, clr_rda pulses, all driven 1 time unit after posedge.
  int unsigned ph = 0;
  int unsigned clr_seen = 0;
  always @(posedge clk) begin
    #1;
    ph = (ph + 1) % 4;
    en = (ph == 0);
    clr_rda = (clr_seq != clr_seen) ||
              (coinc_req && en && pend_valid && pend_dly == 0 && pend_ens == FRAME_EN - 1);
    clr_seen = clr_seq;
  end

  // Single compare process: every cycle against the model, plus literal
  // expectations posted by the stimulus.
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned lit_seen = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    checks++;
    if ({data, rda, ferr, oerr} !== {m_data, m_rda, m_ferr, m_oerr}) begin
      errors++;
      $display("FAIL cycle t=%0t: dut data=%h rda=%b ferr=%b oerr=%b, model data=%h rda=%b ferr=%b oerr=%b",
               $time, data, rda, ferr, oerr, m_data, m_rda, m_ferr, m_oerr);
    end
    if (lit_seq != lit_seen) begin
      lit_seen = lit_seq;
      chk({lit_tag, ".data"}, data, lit_data);
      chk({lit_tag, ".rda"}, {7'd0, rda}, {7'd0, lit_rda});
      chk({lit_tag, ".ferr"}, {7'd0, ferr}, {7'd0, lit_ferr});
      chk({lit_tag, ".oerr"}, {7'd0, oerr}, {7'd0, lit_oerr});
      chk({lit_tag, ".model"}, {m_data[3:0], m_rda, m_ferr, m_oerr, 1'b0},
          {lit_data[3:0], lit_rda, lit_ferr, lit_oerr, 1'b0});
    end
  end

  task automatic post_lit(input string tag, input logic [7:0] d, input logic r,
                          input logic f, input logic o);
    lit_tag  = tag;
    lit_data = d;
    lit_rda  = r;
    lit_ferr = f;
    lit_oerr = o;
    lit_seq++;
    @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    @(posedge clk);
    #1;
    RxD      = 1'b0;
    req_byte = b;
    req_stop = stop_b;
    req_seq++;
    for (int i = 0; i < 8; i++) begin
      repeat (BIT_CLK) @(posedge clk);
      #1;
      RxD = b[i];
    end
    repeat (BIT_CLK) @(posedge clk);
    #1;
    RxD = stop_b;
    repeat (BIT_CLK) @(posedge clk);
    #1;
    RxD = 1'b1;
    repeat (BIT_CLK) @(posedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_seq++;
    @(posedge clk);
    @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    post_lit("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (20) @(posedge clk);

    send_frame(8'hA5, 1'b1);
    post_lit("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
    pulse_clr();
    post_lit("a5_clr", 8'hA5, 1'b0, 1'b0, 1'b0);

    // Short low pulse: false start, nothing changes.
    @(posedge clk);
    #1;
    RxD = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    RxD = 1'b1;
    repeat (200) @(posedge clk);
    post_lit("glitch", 8'hA5, 1'b0, 1'b0, 1'b0);

    send_frame(8'h3C, 1'b1);
    post_lit("3c", 8'h3C, 1'b1, 1'b0, 1'b0);
    pulse_clr();

    send_frame(8'h81, 1'b0);
    post_lit("81_ferr", 8'h3C, 1'b0, 1'b1, 1'b0);
    send_frame(8'h42, 1'b1);
    post_lit("42", 8'h42, 1'b1, 1'b0, 1'b0);
    pulse_clr();

    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    post_lit("overrun", 8'h22, 1'b1, 1'b0, 1'b1);
    pulse_clr();
    post_lit("overrun_clr", 8'h22, 1'b0, 1'b0, 1'b0);

    send_frame(8'h33, 1'b1);
    post_lit("33", 8'h33, 1'b1, 1'b0, 1'b0);
    coinc_req = 1'b1;
    send_frame(8'h55, 1'b1);
    coinc_req = 1'b0;
    post_lit("coinc", 8'h55, 1'b1, 1'b0, 1'b0);
    pulse_clr();

    // Reset in the middle of 0xF0's data bits (bits 0..3 are low).
    @(posedge clk);
    #1;
    RxD      = 1'b0;
    req_byte = 8'hF0;
    req_stop = 1'b1;
    req_seq++;
    repeat (BIT_CLK * 4 + BIT_CLK / 2) @(posedge clk);
    #3;
    rst = 1'b1;
    post_lit("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    // Line still low at release; raise it well before a mid-start sample.
    repeat (8) @(posedge clk);
    #1;
    RxD = 1'b1;
    repeat (300) @(posedge clk);
    post_lit("after_rst", 8'h00, 1'b0, 1'b0, 1'b0);

    send_frame(8'h0F, 1'b1);
    post_lit("0f", 8'h0F, 1'b1, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
